// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART boot loader: sync byte, FSM encodings, byte-lane helper.
// Pure declarations, no logic of its own.
package uart_imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Little-endian word assembly: byte lane idx of word is replaced by b.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit glitch filter, mid-bit sampling.
// One-cycle rx_valid (or rx_ferr on a low stop bit) at the stop-bit sample; no backpressure.
module uart_rx_byte
  import uart_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     r_state, w_state_nxt;
  logic          r_sync1, r_sync2, r_sync3;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          w_fall, w_half, w_bit_end;

  assign w_fall    = r_sync3 & ~r_sync2;
  assign w_half    = (r_cnt == HALF_LAST);
  assign w_bit_end = (r_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
      RX_START: if (w_half) w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_bit_end) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  // Counter restarts at every sample point so each following sample lands mid-bit.
  always_comb begin
    w_cnt_nxt     = r_cnt + CW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_nxt    = r_byte;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt     = '0;
        w_bit_idx_nxt = 3'd0;
      end
      RX_START: if (w_half) w_cnt_nxt = '0;
      RX_DATA: if (w_bit_end) begin
        w_cnt_nxt     = '0;
        w_shift_nxt   = {r_sync2, r_shift[7:1]};
        w_bit_idx_nxt = r_bit_idx + 3'd1;
      end
      RX_STOP: if (w_bit_end) begin
        w_cnt_nxt = '0;
        if (r_sync2) begin
          w_valid_nxt = 1'b1;
          w_byte_nxt  = r_shift;
        end else begin
          w_ferr_nxt = 1'b1;
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_sync3   <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_byte    <= 8'd0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_byte    <= w_byte_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  assign rx_valid = r_valid;
  assign rx_byte  = r_byte;
  assign rx_ferr  = r_ferr;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: parses A5|LEN|words|CSUM from UART, writes imem, releases core_rst on good checksum.
// Write strobe one cycle after the 4th byte of each word; UART has no flow control, so nothing stalls.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  logic        w_rx_valid, w_rx_ferr;
  logic [7:0]  w_rx_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_valid (w_rx_valid),
    .rx_byte  (w_rx_byte),
    .rx_ferr  (w_rx_ferr)
  );

  ld_state_e             r_state, w_state_nxt;
  logic [7:0]            r_len_lo, w_len_lo_nxt;
  logic [15:0]           r_len, w_len_nxt;
  logic [ADDR_WIDTH:0]   r_word_idx, w_word_idx_nxt;
  logic [1:0]            r_byte_idx, w_byte_idx_nxt;
  logic [31:0]           r_word, w_word_nxt;
  logic [7:0]            r_csum, w_csum_nxt;
  logic                  r_imem_we, w_imem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_imem_addr, w_imem_addr_nxt;
  logic [31:0]           r_imem_wdata, w_imem_wdata_nxt;
  logic                  r_core_rst, r_load_done, r_load_err;

  logic [15:0] w_len_rx;
  logic        w_is_sync, w_last_word;
  logic [31:0] w_word_asm;

  assign w_len_rx    = {w_rx_byte, r_len_lo};
  assign w_is_sync   = w_rx_valid && (w_rx_byte == SYNC_BYTE);
  assign w_last_word = (17'(r_word_idx) == ({1'b0, r_len} - 17'd1));
  assign w_word_asm  = put_byte(r_word, r_byte_idx, w_rx_byte);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_is_sync) w_state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_rx_ferr)       w_state_nxt = ST_ERROR;
        else if (w_rx_valid) w_state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_rx_ferr) begin
          w_state_nxt = ST_ERROR;
        end else if (w_rx_valid) begin
          if ({1'b0, w_len_rx} > MAX_WORDS) w_state_nxt = ST_ERROR;
          else if (w_len_rx == 16'd0)       w_state_nxt = ST_CSUM;
          else                              w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_rx_ferr) w_state_nxt = ST_ERROR;
        else if (w_rx_valid && r_byte_idx == 2'd3 && w_last_word) w_state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_rx_ferr)       w_state_nxt = ST_ERROR;
        else if (w_rx_valid) w_state_nxt = (w_rx_byte == r_csum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:   w_state_nxt = ST_DONE;
      ST_ERROR:  if (w_is_sync) w_state_nxt = ST_LEN_LO;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_len_lo_nxt     = r_len_lo;
    w_len_nxt        = r_len;
    w_word_idx_nxt   = r_word_idx;
    w_byte_idx_nxt   = r_byte_idx;
    w_word_nxt       = r_word;
    w_csum_nxt       = r_csum;
    w_imem_we_nxt    = 1'b0;
    w_imem_addr_nxt  = r_imem_addr;
    w_imem_wdata_nxt = r_imem_wdata;
    case (r_state)
      ST_IDLE, ST_ERROR: if (w_is_sync) w_csum_nxt = 8'd0;
      ST_LEN_LO: if (w_rx_valid) w_len_lo_nxt = w_rx_byte;
      ST_LEN_HI: if (w_rx_valid) begin
        w_len_nxt      = w_len_rx;
        w_word_idx_nxt = '0;
        w_byte_idx_nxt = 2'd0;
      end
      ST_DATA: if (w_rx_valid) begin
        w_word_nxt     = w_word_asm;
        w_csum_nxt     = r_csum ^ w_rx_byte;
        w_byte_idx_nxt = r_byte_idx + 2'd1;
        // rx_valid is a single-cycle pulse, so the strobe can never repeat back to back.
        if (r_byte_idx == 2'd3) begin
          w_imem_we_nxt    = 1'b1;
          w_imem_addr_nxt  = r_word_idx[ADDR_WIDTH-1:0];
          w_imem_wdata_nxt = w_word_asm;
          w_word_idx_nxt   = r_word_idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_lo     <= 8'd0;
      r_len        <= 16'd0;
      r_word_idx   <= '0;
      r_byte_idx   <= 2'd0;
      r_word       <= 32'd0;
      r_csum       <= 8'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
      r_core_rst   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_len_lo     <= w_len_lo_nxt;
      r_len        <= w_len_nxt;
      r_word_idx   <= w_word_idx_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_word       <= w_word_nxt;
      r_csum       <= w_csum_nxt;
      r_imem_we    <= w_imem_we_nxt;
      r_imem_addr  <= w_imem_addr_nxt;
      r_imem_wdata <= w_imem_wdata_nxt;
      r_core_rst   <= (w_state_nxt != ST_DONE);
      r_load_done  <= (w_state_nxt == ST_DONE);
      r_load_err   <= (w_state_nxt == ST_ERROR);
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_rst   = r_core_rst;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: frame-level model predicts writes and final flags,
// a per-cycle monitor checks every strobe and the hold behaviour of addr/wdata.
module tb_uart_imem_loader;
  localparam int CPB = 4;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst, load_done, load_err;

  always #5 clk = ~clk;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  exp_a_q[$];
  logic [31:0] exp_d_q[$];
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  logic [7:0]  frm[$];
  logic [7:0]  exp_addr = 8'd0;
  logic [31:0] exp_wdata = 32'd0;
  bit          prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Frame-level model: scan for sync, read length, collect words, verify XOR checksum.
  task automatic model_run(input int ferr_at);
    int i = 0;
    int n;
    bit bad;
    logic [7:0]  cs;
    logic [31:0] w;
    while (i < frm.size() && !m_done) begin
      if (i == ferr_at || frm[i] != 8'hA5) begin i++; continue; end
      m_err = 1'b0;
      i++;
      if (i + 2 > frm.size()) break;
      if (ferr_at == i || ferr_at == i + 1) begin m_err = 1'b1; i = ferr_at + 1; continue; end
      n = int'(frm[i]) + 256 * int'(frm[i+1]);
      i += 2;
      if (n > (1 << AW)) begin m_err = 1'b1; continue; end
      cs = 8'd0;
      bad = 1'b0;
      w = 32'd0;
      for (int k = 0; k < n && !bad; k++) begin
        for (int j = 0; j < 4; j++) begin
          if (i >= frm.size()) begin bad = 1'b1; break; end
          if (i == ferr_at) begin m_err = 1'b1; bad = 1'b1; i++; break; end
          w[8*j +: 8] = frm[i];
          cs = cs ^ frm[i];
          i++;
        end
        if (!bad) begin
          exp_a_q.push_back(8'(k));
          exp_d_q.push_back(w);
        end
      end
      if (bad) continue;
      if (i >= frm.size()) break;
      if (i == ferr_at) begin m_err = 1'b1; i++; continue; end
      if (frm[i] == cs) m_done = 1'b1;
      else              m_err = 1'b1;
      i++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_ok;
    tick(CPB);
    uart_rx = 1'b1;
    tick(3);
  endtask

  task automatic send_frame(input int ferr_at);
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i], i != ferr_at);
    tick(4);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_done = 1'b0;
    m_err = 1'b0;
    exp_a_q.delete();
    exp_d_q.delete();
    tick(1);
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_load_done"}, 32'(load_done), 32'(m_done));
    chk({tag, "_load_err"},  32'(load_err),  32'(m_err));
    chk({tag, "_core_rst"},  32'(core_rst),  32'(!m_done));
    chk({tag, "_pending_writes"}, exp_d_q.size(), 0);
  endtask

  task automatic load_good();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
            8'h93, 8'h02, 8'hA0, 8'h00, 8'h73};
  endtask

  // Per-cycle monitor: outputs sampled on the falling edge.
  initial begin : monitor
    bit rs;
    forever begin
      @(posedge clk);
      rs = rst;
      @(negedge clk);
      if (rs) begin
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_load_err", 32'(load_err), 0);
        exp_addr = 8'd0;
        exp_wdata = 32'd0;
        prev_we = 1'b0;
      end else if (imem_we === 1'b1) begin
        chk("we_back_to_back", 32'(prev_we), 0);
        n_chk++;
        if (exp_d_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", imem_addr, imem_wdata);
        end else begin
          exp_addr = exp_a_q.pop_front();
          exp_wdata = exp_d_q.pop_front();
          chk("write_addr", 32'(imem_addr), 32'(exp_addr));
          chk("write_data", imem_wdata, exp_wdata);
        end
        prev_we = 1'b1;
      end else begin
        chk("imem_we_low", 32'(imem_we), 0);
        chk("hold_addr", 32'(imem_addr), 32'(exp_addr));
        chk("hold_wdata", imem_wdata, exp_wdata);
        prev_we = 1'b0;
      end
    end
  end

  initial begin : stim
    // 1: reset
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("after_rst_core_rst", 32'(core_rst), 1);
    chk("after_rst_load_done", 32'(load_done), 0);
    chk("after_rst_load_err", 32'(load_err), 0);

    // 2: good load, model pinned to hand-computed words
    load_good();
    model_run(-1);
    chk("model_good_nwrites", exp_d_q.size(), 2);
    chk("model_good_w0", exp_d_q[0], 32'h00500113);
    chk("model_good_w1", exp_d_q[1], 32'h00A00293);
    chk("model_good_a1", 32'(exp_a_q[1]), 1);
    chk("model_good_done", 32'(m_done), 1);
    send_frame(-1);
    check_end("good");
    chk("good_lit_done", 32'(load_done), 1);
    chk("good_lit_core_rst", 32'(core_rst), 0);

    // 3: bad checksum, then recovery without reset
    reset_dut();
    load_good();
    frm[11] = 8'h74;
    model_run(-1);
    chk("model_badcs_err", 32'(m_err), 1);
    send_frame(-1);
    check_end("badcs");
    chk("badcs_lit_err", 32'(load_err), 1);
    load_good();
    model_run(-1);
    send_frame(-1);
    check_end("recover");
    chk("recover_lit_err", 32'(load_err), 0);
    chk("recover_lit_done", 32'(load_done), 1);

    // 4: short start-bit glitch, noise bytes, then the good frame
    reset_dut();
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(12);
    load_good();
    frm.push_front(8'h5A);
    frm.push_front(8'hFF);
    frm.push_front(8'h00);
    model_run(-1);
    send_frame(-1);
    check_end("noise");

    // 5: framing error on the third data byte
    reset_dut();
    load_good();
    model_run(5);
    chk("model_ferr_nwrites", exp_d_q.size(), 0);
    chk("model_ferr_err", 32'(m_err), 1);
    send_frame(5);
    check_end("ferr");

    // 6a: oversized length
    reset_dut();
    frm = '{8'hA5, 8'h01, 8'h01};
    model_run(-1);
    chk("model_len_err", 32'(m_err), 1);
    send_frame(-1);
    check_end("len_over");
    // 6b: empty image straight out of ERROR
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_run(-1);
    chk("model_empty_done", 32'(m_done), 1);
    send_frame(-1);
    check_end("empty");
    chk("empty_lit_err", 32'(load_err), 0);

    // 6c: reset in the middle of DATA, then a clean load
    reset_dut();
    frm = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h01};
    model_run(-1);
    send_frame(-1);
    check_end("mid_data");
    reset_dut();
    chk("midrst_core_rst", 32'(core_rst), 1);
    chk("midrst_load_err", 32'(load_err), 0);
    chk("midrst_load_done", 32'(load_done), 0);
    load_good();
    model_run(-1);
    send_frame(-1);
    check_end("after_midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
